// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional-N UART baud generator with oversample, mid-bit and bit-boundary strobes
module uart_baud_gen #(
    parameter int DIV_WIDTH        = 16,
    parameter int FRAC_WIDTH       = 4,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_DIV_INT  = 78,
    parameter int DEFAULT_DIV_FRAC = 2
) (
    input  logic                  clk_12mhz,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sync_clr,
    input  logic                  cfg_load,
    input  logic [DIV_WIDTH-1:0]  cfg_div_int,
    input  logic [FRAC_WIDTH-1:0] cfg_div_frac,
    output logic                  os_tick,
    output logic                  mid_tick,
    output logic                  baud_tick,
    output logic                  baud_clk,
    output logic                  cfg_pending
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    logic [DIV_WIDTH-1:0]  div_int_r;
    logic [FRAC_WIDTH-1:0] div_frac_r;
    logic [DIV_WIDTH-1:0]  pend_int;
    logic [FRAC_WIDTH-1:0] pend_frac;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [FRAC_WIDTH-1:0] acc;
    logic [OS_W-1:0]       os_cnt;
    logic                  run;

    logic [DIV_WIDTH-1:0]  eff_int;
    logic [FRAC_WIDTH-1:0] acc_sum;
    logic                  carry;
    logic [DIV_WIDTH:0]    period_m1;
    logic                  clr;
    logic                  period_end;
    logic                  os_mid;
    logic                  os_last;
    logic                  boundary;

    always_comb begin
        eff_int            = (div_int_r == '0) ? DIV_WIDTH'(1) : div_int_r;
        {carry, acc_sum}   = {1'b0, acc} + {1'b0, div_frac_r};
        period_m1          = {1'b0, eff_int} + {{DIV_WIDTH{1'b0}}, carry} - (DIV_WIDTH+1)'(1);
        clr                = ~en | sync_clr;
        // run delays counting by one edge so the first period spans exactly P cycles after enable
        period_end         = run & ~clr & ({1'b0, cnt} == period_m1);
        os_mid             = (os_cnt == OS_W'(OVERSAMPLE/2 - 1));
        os_last            = (os_cnt == OS_W'(OVERSAMPLE - 1));
        boundary           = period_end & os_last;
    end

    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            div_int_r   <= DIV_WIDTH'(DEFAULT_DIV_INT);
            div_frac_r  <= FRAC_WIDTH'(DEFAULT_DIV_FRAC);
            pend_int    <= '0;
            pend_frac   <= '0;
            cfg_pending <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            os_cnt      <= '0;
            run         <= 1'b0;
            os_tick     <= 1'b0;
            mid_tick    <= 1'b0;
            baud_tick   <= 1'b0;
            baud_clk    <= 1'b0;
        end else begin
            run       <= ~clr;
            os_tick   <= period_end;
            mid_tick  <= period_end & os_mid;
            baud_tick <= boundary;

            if (clr) begin
                cnt      <= '0;
                acc      <= '0;
                os_cnt   <= '0;
                baud_clk <= 1'b0;
            end else if (run) begin
                if (period_end) begin
                    cnt    <= '0;
                    acc    <= acc_sum;
                    os_cnt <= os_cnt + OS_W'(1);
                    if (os_mid)
                        baud_clk <= 1'b1;
                    if (os_last)
                        baud_clk <= 1'b0;
                end else begin
                    cnt <= cnt + DIV_WIDTH'(1);
                end
            end

            // later assignments win: a load on the apply edge stays pending for the next boundary
            if (cfg_load && !en) begin
                div_int_r   <= cfg_div_int;
                div_frac_r  <= cfg_div_frac;
                acc         <= '0;
                cfg_pending <= 1'b0;
            end else begin
                if (cfg_pending && (clr || boundary)) begin
                    div_int_r   <= pend_int;
                    div_frac_r  <= pend_frac;
                    acc         <= '0;
                    cfg_pending <= 1'b0;
                end
                if (cfg_load) begin
                    pend_int    <= cfg_div_int;
                    pend_frac   <= cfg_div_frac;
                    cfg_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - self-checking bench for uart_baud_gen
module tb_uart_baud_gen;

    logic        clk_12mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        sync_clr = 1'b0;
    logic        cfg_load = 1'b0;
    logic [15:0] cfg_div_int = '0;
    logic [3:0]  cfg_div_frac = '0;
    logic        os_tick, mid_tick, baud_tick, baud_clk, cfg_pending;

    uart_baud_gen dut (
        .clk_12mhz    (clk_12mhz),
        .rst_n        (rst_n),
        .en           (en),
        .sync_clr     (sync_clr),
        .cfg_load     (cfg_load),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .os_tick      (os_tick),
        .mid_tick     (mid_tick),
        .baud_tick    (baud_tick),
        .baud_clk     (baud_clk),
        .cfg_pending  (cfg_pending)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    typedef struct {
        int   gap;
        logic mid;
        logic baud;
    } exp_t;

    typedef struct {
        int di;
        int df;
        int bit_cycles;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[6];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_tick = 0;
    int   last_baud = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   last_high = -1;
    int   last_low = -1;
    bit   chk_en = 1'b0;
    logic prev_bclk = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int gap_of(input int di, input int df, input int idx);
        int acc = 0;
        int s = 0;
        int p = 0;
        for (int k = 0; k <= idx; k++) begin
            s   = acc + df;
            p   = ((di == 0) ? 1 : di) + (s / 16);
            acc = s % 16;
        end
        return p;
    endfunction

    function automatic int span(input int di, input int df, input int a, input int b);
        int t = 0;
        for (int k = a; k <= b; k++)
            t += gap_of(di, df, k);
        return t;
    endfunction

    task automatic push_bit(input int di, input int df, input int first, input int n);
        exp_t e;
        for (int k = first; k < first + n; k++) begin
            e.gap  = gap_of(di, df, k);
            e.mid  = (k == 7);
            e.baud = (k == 15);
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk_12mhz) cyc <= cyc + 1;

    always @(negedge clk_12mhz) begin
        exp_t e;
        if (baud_clk && !prev_bclk) begin
            last_low = cyc - fall_cyc;
            rise_cyc = cyc;
        end
        if (!baud_clk && prev_bclk) begin
            last_high = cyc - rise_cyc;
            fall_cyc  = cyc;
        end
        prev_bclk = baud_clk;
        if (baud_tick)
            last_baud = cyc;
        if (os_tick && chk_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_os_tick", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("os_gap", cyc - last_tick, e.gap);
                check("mid_tick", int'(mid_tick), int'(e.mid));
                check("baud_tick", int'(baud_tick), int'(e.baud));
            end
            last_tick = cyc;
        end
    end

    task automatic do_reset();
        chk_en   = 1'b0;
        exp_q.delete();
        en       = 1'b0;
        sync_clr = 1'b0;
        cfg_load = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk_12mhz);
        #1;
        rst_n    = 1'b1;
    endtask

    task automatic start_run();
        @(posedge clk_12mhz);
        #1;
        en        = 1'b1;
        last_tick = cyc + 1;
        start_cyc = cyc + 1;
        chk_en    = 1'b1;
    endtask

    task automatic load_cfg(input int di, input int df);
        @(posedge clk_12mhz);
        #1;
        cfg_load     = 1'b1;
        cfg_div_int  = 16'(di);
        cfg_div_frac = 4'(df);
        @(posedge clk_12mhz);
        #1;
        cfg_load     = 1'b0;
    endtask

    task automatic wait_q_le(input int n, input int limit, input string nm);
        int k = 0;
        while (exp_q.size() > n && k < limit) begin
            @(negedge clk_12mhz);
            #1;
            k++;
        end
        if (exp_q.size() > n)
            check({nm, "_timeout"}, exp_q.size(), n);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_os_tick"}, int'(os_tick), 0);
        check({nm, "_mid_tick"}, int'(mid_tick), 0);
        check({nm, "_baud_tick"}, int'(baud_tick), 0);
        check({nm, "_baud_clk"}, int'(baud_clk), 0);
        check({nm, "_cfg_pending"}, int'(cfg_pending), 0);
    endtask

    initial begin
        tbl[0] = '{di: 78, df: 2,  bit_cycles: 1250};
        tbl[1] = '{di: 10, df: 15, bit_cycles: 175};
        tbl[2] = '{di: 0,  df: 0,  bit_cycles: 16};
        tbl[3] = '{di: 4,  df: 0,  bit_cycles: 64};
        tbl[4] = '{di: 6,  df: 0,  bit_cycles: 96};
        tbl[5] = '{di: 3,  df: 8,  bit_cycles: 56};

        // reset state
        #2;
        check_idle_outputs("reset");
        do_reset();
        repeat (4) @(posedge clk_12mhz);
        #1;
        check_idle_outputs("idle");

        // default divisor, two bits
        start_run();
        push_bit(78, 2, 0, 16);
        push_bit(78, 2, 0, 16);
        wait_q_le(0, 3000, "default");
        check("default_bit_cycles", last_baud - start_cyc, 2500);
        check("default_high", last_high, span(78, 2, 8, 15));
        check("default_low", last_low, span(78, 2, 0, 7));

        // phase clear at os_cnt=5
        do_reset();
        start_run();
        push_bit(78, 2, 0, 5);
        wait_q_le(0, 1000, "pre_clear");
        @(posedge clk_12mhz);
        #1;
        sync_clr = 1'b1;
        @(posedge clk_12mhz);
        #1;
        check("clr_os_tick", int'(os_tick), 0);
        check("clr_mid_tick", int'(mid_tick), 0);
        check("clr_baud_tick", int'(baud_tick), 0);
        check("clr_baud_clk", int'(baud_clk), 0);
        sync_clr  = 1'b0;
        last_tick = cyc + 1;
        push_bit(78, 2, 0, 8);
        wait_q_le(0, 1000, "post_clear");

        // live reload: single load, then overwritten load
        for (int v = 0; v < 2; v++) begin
            int nd;
            nd = (v == 0) ? 4 : 6;
            do_reset();
            start_run();
            push_bit(78, 2, 0, 16);
            push_bit(nd, 0, 0, 16);
            wait_q_le(29, 1000, "reload_pre");
            load_cfg(4, 0);
            check("reload_pending_set", int'(cfg_pending), 1);
            if (v == 1) begin
                wait_q_le(27, 1000, "reload_second");
                load_cfg(6, 0);
                check("reload2_pending_set", int'(cfg_pending), 1);
            end
            wait_q_le(17, 2000, "reload_before_bnd");
            check("reload_pending_hold", int'(cfg_pending), 1);
            wait_q_le(16, 200, "reload_at_bnd");
            check("reload_pending_clr", int'(cfg_pending), 0);
            wait_q_le(0, 500, "reload_post");
            check("reload_total", last_baud - start_cyc, 1250 + 16 * nd);
        end

        // idle loads from the vector table
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_12mhz);
            #1;
            en     = 1'b0;
            chk_en = 1'b0;
            exp_q.delete();
            repeat (2) @(posedge clk_12mhz);
            load_cfg(tbl[i].di, tbl[i].df);
            check("idle_load_pending", int'(cfg_pending), 0);
            start_run();
            push_bit(tbl[i].di, tbl[i].df, 0, 16);
            wait_q_le(0, 2 * tbl[i].bit_cycles + 50, "vec_bit");
            check("vec_bit_cycles", last_baud - start_cyc, tbl[i].bit_cycles);
            check("vec_high", last_high, span(tbl[i].di, tbl[i].df, 8, 15));
        end

        // async reset mid-bit with a pending config
        do_reset();
        start_run();
        push_bit(78, 2, 0, 16);
        wait_q_le(13, 1000, "ares_pre");
        load_cfg(4, 0);
        check("ares_pending_set", int'(cfg_pending), 1);
        wait_q_le(5, 1000, "ares_mid");
        check("ares_baud_clk_high", int'(baud_clk), 1);
        @(posedge clk_12mhz);
        #3;
        rst_n  = 1'b0;
        chk_en = 1'b0;
        exp_q.delete();
        #1;
        check_idle_outputs("ares");
        en = 1'b0;
        repeat (2) @(posedge clk_12mhz);
        #1;
        rst_n = 1'b1;
        start_run();
        push_bit(78, 2, 0, 16);
        wait_q_le(0, 2000, "ares_resume");
        check("ares_bit_cycles", last_baud - start_cyc, 1250);
        check("ares_pending_gone", int'(cfg_pending), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
